// File: rtl/pc_fetch_pkg.sv
// Shared types and widths for the fetch stage.
// Optional halt detection is enabled with PC_FETCH_HALT_EN.
package pc_fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int OP_W   = 16;

  localparam logic [OP_W-1:0] HALT_OP = 16'hFFFF;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_fetch.sv
// Fetch stage: PC sequencing, branch redirect, stall hold, sync ROM.
// Define PC_FETCH_HALT_EN to stop fetch after issuing 16'hFFFF.
import pc_fetch_pkg::*;

module pc_fetch #(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [OP_W-1:0]   NOP_OP   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              BR_in,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [OP_W-1:0]   imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [OP_W-1:0]   opCode,
  output logic              en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              en_q, en_d;

  logic take;
  logic in_halt;
  logic hold;
  logic halt_hit;

  assign in_halt = (state_q == HALT);
  assign take    = BR_in & en_q & ~stall;
  assign hold    = stall & ~in_halt;

`ifdef PC_FETCH_HALT_EN
  assign halt_hit = (state_q == RUN) & en_q & ~stall
                  & (op_q == HALT_OP);
  assign halted   = in_halt;
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // en is always 0 in HALT, so these terms never overlap
  always_comb begin
    imem_addr = fetch_pc_q;
    unique case (1'b1)
      in_halt: imem_addr = req_pc_q;
      take:    imem_addr = br_target;
      hold:    imem_addr = req_pc_q;
      default: imem_addr = fetch_pc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pc_d       = pc_q;
    op_d       = op_q;
    en_d       = en_q;
    if (!stall && !in_halt) begin
      req_pc_d   = imem_addr;
      fetch_pc_d = imem_addr + ADDR_W'(1);
    end
    unique case (state_q)
      FILL: begin
        if (!stall) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (halt_hit) begin
            state_d = HALT;
            en_d    = 1'b0;
            op_d    = NOP_OP;
          end else if (take) begin
            en_d = 1'b0;
            op_d = NOP_OP;
          end else begin
            op_d = imem_data;
            pc_d = req_pc_q;
            en_d = 1'b1;
          end
        end
      end
      HALT: begin
        en_d = 1'b0;
        op_d = NOP_OP;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pc_q       <= RESET_PC;
      op_q       <= NOP_OP;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      en_q       <= en_d;
    end
  end

  assign opCode = op_q;
  assign en     = en_q;
  assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus random traffic
// against a cycle-level issue model; covers PC_FETCH_HALT_EN if set.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        BR_in;
  logic [7:0]  br_target;
  logic [15:0] imem_data, imem_data_w;
  logic [7:0]  imem_addr, imem_addr_w;
  logic [15:0] opCode, opCode_w;
  logic        en, en_w;
  logic [7:0]  pc_out, pc_out_w;
  logic        halted, halted_w;

  logic [15:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PC_FETCH_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  // model of the issue stream for the RESET_PC=0 instance
  logic        m_en;
  logic [15:0] m_op;
  logic [7:0]  m_pc;
  logic [7:0]  m_next;
  logic [7:0]  m_haddr;
  int          m_wait;
  logic        m_halt;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data   <= rom[imem_addr];
  always @(posedge clk) imem_data_w <= rom[imem_addr_w];

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .BR_in(BR_in),
    .br_target(br_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .opCode(opCode), .en(en),
    .pc_out(pc_out), .halted(halted)
  );

  pc_fetch #(.RESET_PC(8'hFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .BR_in(BR_in),
    .br_target(br_target), .imem_data(imem_data_w),
    .imem_addr(imem_addr_w), .opCode(opCode_w), .en(en_w),
    .pc_out(pc_out_w), .halted(halted_w)
  );

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_en = 0; m_op = 16'h0; m_pc = 8'h00;
      m_next = 8'h00; m_wait = 1; m_halt = 0;
    end else if (m_halt || stall) begin
    end else if (HALT_ON && m_en && m_op == 16'hFFFF) begin
      m_halt = 1; m_en = 0; m_op = 16'h0;
      m_haddr = m_next + 8'd1;
    end else if (BR_in && m_en) begin
      m_en = 0; m_op = 16'h0;
      m_next = br_target; m_wait = 0;
    end else if (m_wait != 0) begin
      m_wait--;
    end else begin
      m_en = 1; m_op = rom[m_next];
      m_pc = m_next; m_next = m_next + 8'd1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; stall = 0; BR_in = 0; br_target = 8'h00;
    tick();
    rst_n = 1;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0100 + 16'(i);
  endtask

  task automatic test_reset();
    load_rom();
    do_reset();
    n_checks += 5;
    if (en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en got %b want 0", en);
    end
    if (opCode !== 16'h0000) begin
      n_fail++; $display("FAIL reset_op got %h want 0000", opCode);
    end
    if (pc_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc got %h want 00", pc_out);
    end
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_halted got %b want 0", halted);
    end
    if (pc_out_w !== 8'hFE) begin
      n_fail++; $display("FAIL reset_pc_w got %h want FE", pc_out_w);
    end
  endtask

  task automatic test_fill_run();
    logic [15:0] exp_op;
    load_rom();
    do_reset();
    tick();
    n_checks++;
    if (en !== 1'b0 || opCode !== 16'h0) begin
      n_fail++;
      $display("FAIL fill_bubble got en=%b op=%h want 0/0000",
               en, opCode);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_op = 16'h0100 + 16'(i);
      n_checks++;
      if (en !== 1'b1 || opCode !== exp_op || pc_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL fill_seq%0d got en=%b op=%h pc=%h want 1/%h/%h",
                 i, en, opCode, pc_out, exp_op, 8'(i));
      end
    end
  endtask

  task automatic test_branch();
    load_rom();
    do_reset();
    repeat (7) tick();
    n_checks++;
    if (pc_out !== 8'h05 || opCode !== 16'h0105) begin
      n_fail++;
      $display("FAIL br_pre got pc=%h op=%h want 05/0105",
               pc_out, opCode);
    end
    BR_in = 1; br_target = 8'h40;
    tick();
    BR_in = 0;
    n_checks++;
    if (en !== 1'b0 || opCode !== 16'h0000) begin
      n_fail++;
      $display("FAIL br_bubble got en=%b op=%h want 0/0000",
               en, opCode);
    end
    tick();
    n_checks++;
    if (en !== 1'b1 || opCode !== 16'h0140 || pc_out !== 8'h40) begin
      n_fail++;
      $display("FAIL br_tgt got en=%b op=%h pc=%h want 1/0140/40",
               en, opCode, pc_out);
    end
    tick();
    n_checks++;
    if (opCode !== 16'h0141 || pc_out !== 8'h41) begin
      n_fail++;
      $display("FAIL br_next got op=%h pc=%h want 0141/41",
               opCode, pc_out);
    end
  endtask

  task automatic test_stall();
    load_rom();
    do_reset();
    repeat (18) tick();
    stall = 1; BR_in = 1; br_target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (en !== 1'b1 || opCode !== 16'h0110 || pc_out !== 8'h10
          || imem_addr !== 8'h11) begin
        n_fail++;
        $display("FAIL stall_hold%0d got en=%b op=%h pc=%h a=%h",
                 i, en, opCode, pc_out, imem_addr);
      end
    end
    stall = 0; BR_in = 0;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_checks++;
      if (opCode !== 16'h0110 + 16'(i) || pc_out !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL stall_resume%0d got op=%h pc=%h want %h/%h",
                 i, opCode, pc_out, 16'h0110 + 16'(i), 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    load_rom();
    do_reset();
    tick();
    exp_pc = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (en_w !== 1'b1 || pc_out_w !== exp_pc
          || opCode_w !== 16'h0100 + 16'(exp_pc)) begin
        n_fail++;
        $display("FAIL wrap%0d got pc=%h op=%h want pc=%h",
                 i, pc_out_w, opCode_w, exp_pc);
      end
      exp_pc = exp_pc + 8'd1;
    end
  endtask

  task automatic test_reset_mid();
    load_rom();
    do_reset();
    repeat (5) tick();
    stall = 1;
    tick();
    rst_n = 0;
    tick();
    n_checks++;
    if (en !== 1'b0 || opCode !== 16'h0 || pc_out !== 8'h00
        || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_stall got en=%b op=%h pc=%h a=%h",
               en, opCode, pc_out, imem_addr);
    end
    rst_n = 1; stall = 0;
    repeat (2) tick();
    n_checks++;
    if (en !== 1'b1 || opCode !== 16'h0100 || pc_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_stall_restart got en=%b op=%h pc=%h",
               en, opCode, pc_out);
    end
    repeat (4) tick();
    BR_in = 1; br_target = 8'h40;
    tick();
    BR_in = 0; rst_n = 0;
    tick();
    n_checks++;
    if (en !== 1'b0 || opCode !== 16'h0 || pc_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_branch got en=%b op=%h pc=%h",
               en, opCode, pc_out);
    end
    rst_n = 1;
    tick();
    n_checks++;
    if (en !== 1'b0) begin
      n_fail++; $display("FAIL rst_branch_fill got en=%b want 0", en);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (opCode !== 16'h0100 + 16'(i) || pc_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL rst_branch_seq%0d got op=%h pc=%h",
                 i, opCode, pc_out);
      end
    end
  endtask

  task automatic test_ffff();
    load_rom();
    rom[3] = 16'hFFFF;
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (en !== 1'b1 || opCode !== 16'hFFFF || pc_out !== 8'h03) begin
      n_fail++;
      $display("FAIL ffff_issue got en=%b op=%h pc=%h",
               en, opCode, pc_out);
    end
`ifdef PC_FETCH_HALT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (en !== 1'b0 || opCode !== 16'h0 || halted !== 1'b1
          || imem_addr !== 8'h05) begin
        n_fail++;
        $display("FAIL halt%0d got en=%b op=%h h=%b a=%h",
                 i, en, opCode, halted, imem_addr);
      end
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if (halted !== 1'b0 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clear got h=%b en=%b want 0/0", halted, en);
    end
`else
    tick();
    n_checks++;
    if (en !== 1'b1 || opCode !== 16'h0104 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL ffff_plain got en=%b op=%h h=%b want 1/0104/0",
               en, opCode, halted);
    end
`endif
    rom[3] = 16'h0103;
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      if (HALT_ON && v == 16'hFFFF) v = 16'h0;
      rom[i] = v;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      stall     = ($urandom_range(0, 9) < 3);
      BR_in     = ($urandom_range(0, 9) < 2);
      br_target = 8'($urandom);
      tick();
      n_checks++;
      if (en !== m_en || opCode !== m_op || halted !== m_halt
          || (m_en && pc_out !== m_pc)) begin
        n_fail++;
        $display("FAIL rand%0d got en=%b op=%h pc=%h want %b/%h/%h",
                 c, en, opCode, pc_out, m_en, m_op, m_pc);
      end
    end
    rst_n = 1; stall = 0; BR_in = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; BR_in = 0; br_target = 8'h00;
    m_en = 0; m_op = 16'h0; m_pc = 8'h0; m_next = 8'h0;
    m_haddr = 8'h0; m_wait = 1; m_halt = 0;
    @(negedge clk);
    test_reset();
    test_fill_run();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_ffff();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
